kd_tree_root_ctrl: RTL and testbench

//   Top-level sequencer for the kd-tree node array. Drives the root node's top command/data

---
 rtl/kd_tree_root_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_kd_tree_root_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kd_tree_root_ctrl.sv
// Root sequencer for the kd-tree node array: tree reset, center fill, sort-axis configuration.
// Optional per-phase watchdog enabled by defining KD_CTRL_TIMEOUT_EN.
module kd_tree_root_ctrl #(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned CMD_W       = 5,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_num_centers,
  input  logic [DATA_W-1:0] i_axis_init,
  input  logic [DATA_W-1:0] i_center_data,
  input  logic              i_center_valid,
  output logic              o_center_ready,
  output logic [CMD_W-1:0]  o_cmd_to_root,
  output logic [DATA_W-1:0] o_data_to_root,
  input  logic [CMD_W-1:0]  i_cmd_from_root,
  input  logic [DATA_W-1:0] i_data_from_root,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [CMD_W-1:0] CMD_NOP       = CMD_W'(5'b00000);
  localparam logic [CMD_W-1:0] CMD_RST       = CMD_W'(5'b11111);
  localparam logic [CMD_W-1:0] CMD_RST_DONE  = CMD_W'(5'b11110);
  localparam logic [CMD_W-1:0] CMD_FILL      = CMD_W'(5'b00001);
  localparam logic [CMD_W-1:0] CMD_FILL_DONE = CMD_W'(5'b00101);
  localparam logic [CMD_W-1:0] CMD_AXIS      = CMD_W'(5'b00010);
  localparam logic [CMD_W-1:0] CMD_AXIS_DONE = CMD_W'(5'b00111);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_FILL, S_FILL_WAIT, S_AXIS, S_DONE, S_ERROR
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_num, w_num_nxt;
  logic [DATA_W-1:0]  r_axis, w_axis_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt, w_count_inc;
  logic [CMD_W-1:0]   r_cmd, w_cmd_nxt;
  logic [DATA_W-1:0]  r_data, w_data_nxt;
  logic               r_ready, r_busy, r_done, r_error;
  logic               w_ready_nxt, w_busy_nxt, w_done_nxt, w_error_nxt;
  logic               w_accept;
  logic               w_unused;

  // Root data bus is debug-only; fold it away so it stays visibly unused.
  assign w_unused = ^{i_data_from_root, 32'(TIMEOUT_CYC)};

  assign w_accept    = (r_state == S_FILL) && r_ready && i_center_valid;
  assign w_count_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);

`ifdef KD_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] r_wd;
  logic            w_wd_phase;
  logic            w_wd_expire;

  assign w_wd_phase  = (r_state == S_RST) || (r_state == S_FILL_WAIT) || (r_state == S_AXIS);
  assign w_wd_expire = w_wd_phase && (r_wd == WD_W'(TIMEOUT_CYC - 1));

  // Phase watchdog: restarts on every state change; host stalls in FILL do not count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wd <= '0;
    end else if (w_state_nxt != r_state) begin
      r_wd <= '0;
    end else if ((w_wd_phase || (r_state == S_FILL && i_center_valid)) && (r_wd != '1)) begin
      r_wd <= r_wd + WD_W'(1);
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_num   <= '0;
      r_axis  <= '0;
      r_count <= '0;
      r_cmd   <= CMD_NOP;
      r_data  <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_num   <= w_num_nxt;
      r_axis  <= w_axis_nxt;
      r_count <= w_count_nxt;
      r_cmd   <= w_cmd_nxt;
      r_data  <= w_data_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_error <= w_error_nxt;
    end
  end

  // Next state, then registered outputs derived from the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_num_nxt   = r_num;
    w_axis_nxt  = r_axis;
    w_count_nxt = r_count;
    w_cmd_nxt   = CMD_NOP;
    w_data_nxt  = '0;

    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_num_nxt   = i_num_centers;
          w_axis_nxt  = i_axis_init;
          w_count_nxt = '0;
          w_state_nxt = S_RST;
        end
      end
      S_RST: begin
        if (i_cmd_from_root == CMD_RST_DONE) begin
          w_state_nxt = (r_num == '0) ? S_AXIS : S_FILL;
        end
      end
      S_FILL: begin
        if (i_cmd_from_root == CMD_FILL_DONE) begin
          w_state_nxt = S_ERROR;
        end else if (w_accept) begin
          w_count_nxt = w_count_inc;
          if (w_count_inc == r_num) begin
            w_state_nxt = S_FILL_WAIT;
          end
        end
      end
      S_FILL_WAIT: begin
        if (i_cmd_from_root == CMD_FILL_DONE) begin
          w_state_nxt = S_AXIS;
        end
      end
      S_AXIS: begin
        if (i_cmd_from_root == CMD_AXIS_DONE) begin
          w_state_nxt = S_DONE;
        end
      end
      S_ERROR: w_state_nxt = S_ERROR;
      default: w_state_nxt = S_IDLE;
    endcase

`ifdef KD_CTRL_TIMEOUT_EN
    if (w_wd_expire && (w_state_nxt == r_state)) begin
      w_state_nxt = S_ERROR;
    end
`endif

    unique case (w_state_nxt)
      S_RST: begin
        w_cmd_nxt  = CMD_RST;
        w_data_nxt = '0;
      end
      S_FILL: begin
        w_cmd_nxt  = w_accept ? CMD_FILL : CMD_NOP;
        w_data_nxt = w_accept ? i_center_data : r_data;
      end
      S_FILL_WAIT: begin
        w_cmd_nxt  = CMD_FILL;
        w_data_nxt = w_accept ? i_center_data : r_data;
      end
      S_AXIS: begin
        w_cmd_nxt  = CMD_AXIS;
        w_data_nxt = w_axis_nxt;
      end
      default: begin
        w_cmd_nxt  = CMD_NOP;
        w_data_nxt = '0;
      end
    endcase
  end

  assign w_ready_nxt = (w_state_nxt == S_FILL);
  assign w_busy_nxt  = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE) &&
                       (w_state_nxt != S_ERROR);
  assign w_done_nxt  = (w_state_nxt == S_DONE);
  assign w_error_nxt = (w_state_nxt == S_ERROR);

  assign o_center_ready = r_ready;
  assign o_cmd_to_root  = r_cmd;
  assign o_data_to_root = r_data;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;

endmodule

// File: tb/tb_kd_tree_root_ctrl.sv
// Scoreboard bench for kd_tree_root_ctrl: expected output changes are queued by the stimulus,
// a negedge monitor pops one entry whenever the DUT output vector changes.
module tb_kd_tree_root_ctrl;

  localparam logic [4:0] C_NOP   = 5'b00000;
  localparam logic [4:0] C_RST   = 5'b11111;
  localparam logic [4:0] C_RSTD  = 5'b11110;
  localparam logic [4:0] C_FILL  = 5'b00001;
  localparam logic [4:0] C_FILLD = 5'b00101;
  localparam logic [4:0] C_AXIS  = 5'b00010;
  localparam logic [4:0] C_AXISD = 5'b00111;

  typedef struct packed {
    logic [4:0]  cmd;
    logic [23:0] data;
    logic        ready;
    logic        busy;
    logic        done;
    logic        error;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_centers = '0;
  logic [23:0] axis_init = '0;
  logic [23:0] center_data = '0;
  logic        center_valid = 1'b0;
  logic        center_ready;
  logic [4:0]  cmd_to_root;
  logic [23:0] data_to_root;
  logic [4:0]  cmd_from_root = C_NOP;
  logic [23:0] data_from_root = '0;
  logic        busy, done, error;

  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  int   rst_cyc = 0;
  int   acc_cyc = 0;
  int   hold_cyc = 0;

  kd_tree_root_ctrl #(
    .DATA_W(24), .CMD_W(5), .CNT_W(8), .TIMEOUT_CYC(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_num_centers(num_centers), .i_axis_init(axis_init),
    .i_center_data(center_data), .i_center_valid(center_valid),
    .o_center_ready(center_ready),
    .o_cmd_to_root(cmd_to_root), .o_data_to_root(data_to_root),
    .i_cmd_from_root(cmd_from_root), .i_data_from_root(data_from_root),
    .o_busy(busy), .o_done(done), .o_error(error)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] c, input logic [23:0] d,
                              input logic r, input logic b, input logic dn, input logic e);
    vec_t v;
    v.cmd = c; v.data = d; v.ready = r; v.busy = b; v.done = dn; v.error = e;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: pops an expectation on every change of the DUT output vector.
  initial begin : monitor
    vec_t prev, cur, want;
    prev = '1;
    forever begin
      @(negedge clk);
      cur = mk(cmd_to_root, data_to_root, center_ready, busy, done, error);
      if (mon_en) begin
        if (cur.cmd == C_RST) rst_cyc++;
        if (center_ready && center_valid) acc_cyc++;
        if (cur.cmd == C_FILL && !cur.ready) hold_cyc++;
        if (cur != prev) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL out_seq unexpected: got cmd=%b data=%h rdy=%b busy=%b done=%b err=%b",
                     cur.cmd, cur.data, cur.ready, cur.busy, cur.done, cur.error);
          end else begin
            want = exp_q.pop_front();
            if (cur != want) begin
              n_err++;
              $display("FAIL out_seq: got cmd=%b data=%h rdy=%b busy=%b done=%b err=%b want cmd=%b data=%h rdy=%b busy=%b done=%b err=%b",
                       cur.cmd, cur.data, cur.ready, cur.busy, cur.done, cur.error,
                       want.cmd, want.data, want.ready, want.busy, want.done, want.error);
            end
          end
          prev = cur;
        end
      end
    end
  end

  initial begin : stimulus
    int snap;
    vec_t v_reset;
    v_reset = mk(C_NOP, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    tick(2);
    exp_q.push_back(v_reset);
    mon_en = 1'b1;
    rst = 1'b0;
    tick(2);

    // 1: rst for 4 cycles, then three centers A,B,C
    start = 1'b1; num_centers = 8'd3; axis_init = 24'd1;
    exp_q.push_back(mk(C_RST, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    snap = rst_cyc;
    tick(1);
    start = 1'b0;
    tick(3);
    cmd_from_root = C_RSTD;
    exp_q.push_back(mk(C_NOP, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0));
    tick(1);
    check_int("rst_cycles", rst_cyc - snap, 4);
    cmd_from_root = C_NOP;
    snap = acc_cyc;
    center_valid = 1'b1; center_data = 24'hAAAAAA;
    exp_q.push_back(mk(C_FILL, 24'hAAAAAA, 1'b1, 1'b1, 1'b0, 1'b0));
    tick(1);
    center_data = 24'hBBBBBB;
    exp_q.push_back(mk(C_FILL, 24'hBBBBBB, 1'b1, 1'b1, 1'b0, 1'b0));
    tick(1);
    center_data = 24'hCCCCCC;
    exp_q.push_back(mk(C_FILL, 24'hCCCCCC, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1);
    center_valid = 1'b0;
    check_int("accepts_3", acc_cyc - snap, 3);

    // 2: fill_done two cycles after C, then axis configuration and done
    snap = hold_cyc;
    tick(1);
    cmd_from_root = C_FILLD;
    exp_q.push_back(mk(C_AXIS, 24'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1);
    cmd_from_root = C_NOP;
    check_int("fill_hold_cycles", hold_cyc - snap, 2);
    tick(1);
    cmd_from_root = C_AXISD;
    exp_q.push_back(mk(C_NOP, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick(1);
    cmd_from_root = C_NOP;
    tick(2);

    // 3: restart from DONE, early fill_done after 2 of 4 centers
    start = 1'b1; num_centers = 8'd4; axis_init = 24'd2;
    exp_q.push_back(mk(C_RST, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1);
    start = 1'b0;
    cmd_from_root = C_RSTD;
    exp_q.push_back(mk(C_NOP, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0));
    tick(1);
    cmd_from_root = C_NOP;
    center_valid = 1'b1; center_data = 24'h111111;
    exp_q.push_back(mk(C_FILL, 24'h111111, 1'b1, 1'b1, 1'b0, 1'b0));
    tick(1);
    center_data = 24'h222222;
    exp_q.push_back(mk(C_FILL, 24'h222222, 1'b1, 1'b1, 1'b0, 1'b0));
    tick(1);
    center_valid = 1'b0;
    cmd_from_root = C_FILLD;
    exp_q.push_back(mk(C_NOP, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    tick(1);
    cmd_from_root = C_NOP;
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    check_int("error_sticky", int'(error), 1);
    rst = 1'b1;
    exp_q.push_back(v_reset);
    tick(1);
    rst = 1'b0;
    tick(2);

    // 4/5: valid gaps in FILL, start ignored in FILL, rst during AXIS
    start = 1'b1; num_centers = 8'd2; axis_init = 24'd5;
    exp_q.push_back(mk(C_RST, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1);
    start = 1'b0;
    cmd_from_root = C_RSTD;
    exp_q.push_back(mk(C_NOP, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0));
    tick(1);
    cmd_from_root = C_NOP;
    snap = acc_cyc;
    center_valid = 1'b1; center_data = 24'h0E0E0E;
    exp_q.push_back(mk(C_FILL, 24'h0E0E0E, 1'b1, 1'b1, 1'b0, 1'b0));
    tick(1);
    center_valid = 1'b0;
    start = 1'b1;
    exp_q.push_back(mk(C_NOP, 24'h0E0E0E, 1'b1, 1'b1, 1'b0, 1'b0));
    tick(1);
    start = 1'b0;
    tick(1);
    center_valid = 1'b1; center_data = 24'h0F0F0F;
    exp_q.push_back(mk(C_FILL, 24'h0F0F0F, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1);
    center_valid = 1'b0;
    check_int("accepts_with_gaps", acc_cyc - snap, 2);
    cmd_from_root = C_FILLD;
    exp_q.push_back(mk(C_AXIS, 24'd5, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1);
    cmd_from_root = C_NOP;
    tick(1);
    rst = 1'b1;
    exp_q.push_back(v_reset);
    tick(1);
    rst = 1'b0;
    tick(2);

    // 6: root never answers rst
    start = 1'b1; num_centers = 8'd1; axis_init = 24'd0;
    exp_q.push_back(mk(C_RST, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1);
    start = 1'b0;
`ifdef KD_CTRL_TIMEOUT_EN
    snap = rst_cyc;
    exp_q.push_back(mk(C_NOP, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    tick(30);
    check_int("timeout_rst_cycles", rst_cyc - snap, 16);
    check_int("timeout_error", int'(error), 1);
`else
    tick(100);
    check_int("stall_cmd_rst", int'(cmd_to_root), int'(C_RST));
    check_int("stall_error", int'(error), 0);
`endif
    rst = 1'b1;
    exp_q.push_back(v_reset);
    tick(1);
    rst = 1'b0;
    tick(3);

    check_int("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
